// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes used by the decoder and the EX-stage
// blocks, plus the multiply sequencer state encoding.
package alu_pkg;

  localparam int ALU_CTRL_BITS = 3;

  localparam logic [ALU_CTRL_BITS-1:0] ALU_AND     = 3'b000;
  localparam logic [ALU_CTRL_BITS-1:0] ALU_OR      = 3'b001;
  localparam logic [ALU_CTRL_BITS-1:0] ALU_ADD     = 3'b010;
  localparam logic [ALU_CTRL_BITS-1:0] ALU_SUB     = 3'b100;
  localparam logic [ALU_CTRL_BITS-1:0] ALU_MUL     = 3'b101;
  localparam logic [ALU_CTRL_BITS-1:0] ALU_SLT     = 3'b110;
  localparam logic [ALU_CTRL_BITS-1:0] ALU_INVALID = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mul_state_t;

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiply datapath: multiplicand/multiplier shift registers and
// the low-word accumulator. Sequencing is owned by mul_sequencer.
module mul_shift_add_dp #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             clear,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] acc_next
);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;

  // Low-word partial product; bits shifted past WIDTH are dropped on purpose.
  assign acc_next = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (load || clear) begin
      acc <= '0;
    end else if (step) begin
      acc <= acc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      mcand  <= src_a;
      mplier <= src_b;
    end else if (step) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// EX-stage multiply controller: freezes the pipeline while a fixed-latency
// shift-add multiply runs, then presents the low product for one cycle.
import alu_pkg::*;

module mul_sequencer #(
  parameter int                    WIDTH      = 32,
  parameter int                    ALU_CTRL_W = 3,
  parameter logic [ALU_CTRL_W-1:0] MUL_CODE   = ALU_MUL
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ALU_CTRL_W-1:0] alu_control,
  input  logic                  ex_valid,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      src_a,
  input  logic [WIDTH-1:0]      src_b,
  output logic                  stall,
  output logic                  busy,
  output logic                  result_valid,
  output logic [WIDTH-1:0]      mul_result
);

  localparam int              CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  mul_state_t       state;
  logic [CNT_W-1:0] count;
  logic             start;
  logic             dp_step;
  logic             dp_clear;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;

  // Gating on IDLE keeps the mul still sitting in EX during DONE from restarting.
  assign start    = ex_valid && (alu_control == MUL_CODE) && !flush && (state == IDLE);
  assign stall    = start || (state == BUSY);
  assign dp_step  = (state == BUSY) && !flush;
  assign dp_clear = (state == BUSY) && flush;

  mul_shift_add_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk      (clk),
    .reset    (reset),
    .load     (start),
    .step     (dp_step),
    .clear    (dp_clear),
    .src_a    (src_a),
    .src_b    (src_b),
    .acc      (acc),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      mul_result   <= '0;
    end else begin
      case (state)
        IDLE: begin
          result_valid <= 1'b0;
          if (start) begin
            count <= '0;
            busy  <= 1'b1;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (flush) begin
            count <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (count == LAST) begin
            // Capture the final iteration's sum so DONE shows the full product.
            busy         <= 1'b0;
            result_valid <= 1'b1;
            mul_result   <= acc_next;
            state        <= DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE: begin
          result_valid <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          busy         <= 1'b0;
          result_valid <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule
